multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Initiator side of the iterative multiply/divide unit interface.
- Accepts one-cycle ctrl_MULT/ctrl_DIV requests from the processor pipeline and latches the operands.
- Clears and starts the selected iterative unit, holds its operands stable, and waits for its ready flag.
- Returns the result/exception to the pipeline with a single-cycle data_resultRDY pulse; also drives a busy/stall signal.

Parameters:
- WIDTH, 32, operand/result width.
- UNIT_CYCLES, 32, nominal iterations of each unit (documentation/timeout base only).
- TIMEOUT_CYCLES, 40, watchdog limit in RUN (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ctrl_MULT  in  1  start multiply (one-cycle pulse)
- ctrl_DIV  in  1  start divide (one-cycle pulse)
- data_operandA  in  WIDTH  operand A, sampled when a ctrl is high
- data_operandB  in  WIDTH  operand B, sampled when a ctrl is high
- unit_operandA  out  WIDTH  latched A driven to both units
- unit_operandB  out  WIDTH  latched B driven to both units
- mult_clr  out  1  restart pulse to multiplier
- div_clr  out  1  restart pulse to divider
- mult_result  in  WIDTH  multiplier result
- mult_exception  in  1  multiplier overflow
- mult_rdy  in  1  multiplier done
- div_result  in  WIDTH  divider result
- div_exception  in  1  divider exception
- div_rdy  in  1  divider done
- data_result  out  WIDTH  registered result
- data_exception  out  1  registered exception
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  operation in flight (pipeline stall)

Behaviour:
- Reset: state IDLE.
  - All outputs 0: operands, clr lines, data_result, data_exception, data_resultRDY, busy.
  - An op register (MULT/DIV) clears to MULT.
  - Reset mid-operation abandons the operation; no RDY pulse is produced.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - ctrl_MULT xor ctrl_DIV -> latch A, B and op; go to START.
  - Both ctrls high -> illegal; go directly to DONE with result 0, exception 1.
  - DIV with data_operandB == 0 -> short-circuit to DONE with result 0, exception 1; unit not started.
- START (exactly 1 cycle):
  - Assert the selected clr only (mult_clr or div_clr); busy=1. Go to RUN.
  - Unit rdy inputs are ignored in START (stale value from the previous op).
- RUN:
  - busy=1; operands held constant.
  - Selected unit's rdy=1 -> capture its result and exception into the output registers; go to DONE.
  - The other unit's rdy is ignored.
- DONE (1 cycle):
  - data_resultRDY=1; busy=0; go to IDLE.
  - data_result and data_exception hold their values until the next completion or reset.
- New request in START/RUN/DONE:
  - Aborts the current operation and relatches operands/op; go to START. No RDY pulse for the aborted op.
  - Same two-ctrls and divide-by-zero rules as IDLE.
- Latency: ctrl cycle T -> START at T+1 -> RUN from T+2 -> rdy at cycle R -> data_resultRDY at R+1.
  - With UNIT_CYCLES=32, data_resultRDY arrives at T+34.
  - Short-circuit cases: data_resultRDY at T+1.
- busy is registered: 1 in START and RUN, 0 otherwise.

Optional Feature:
- MULTDIV_TIMEOUT_EN defined:
  - A cycle counter runs in RUN and is cleared on entering START.
  - Reaching TIMEOUT_CYCLES without rdy -> DONE with result 0, exception 1.
- Not defined: no counter; RUN waits indefinitely for rdy.

Decomposition:
- Shared package multdiv_pkg holds:
  - state enum (IDLE, START, RUN, DONE);
  - op enum (OP_MULT, OP_DIV);
  - WIDTH default.
- Sub-module multdiv_timeout (cycle counter plus compare), instantiated only under MULTDIV_TIMEOUT_EN.
- The FSM and output registers stay in multdiv_ctrl.

Test Plan:
- Reset, then idle: all outputs 0. Assert reset during RUN: busy drops immediately, no RDY pulse.
- ctrl_MULT with A=7, B=-3, model rdy 32 cycles after mult_clr with result -21:
  - mult_clr pulses at T+1; div_clr stays 0;
  - data_resultRDY at T+34 with data_result=0xFFFFFFEB, exception 0.
- ctrl_DIV with A=100, B=7, model result 14: div_clr pulses once; RDY with data_result=14. Divider rdy held 1 during START is ignored.
- ctrl_DIV with B=0: no clr pulse; data_resultRDY at T+1 with data_result=0, exception 1.
- ctrl_MULT, then ctrl_DIV 10 cycles later: second latch wins; div_clr pulses; exactly one RDY pulse, carrying the divide result.
- With MULTDIV_TIMEOUT_EN and rdy never asserted: RDY after TIMEOUT_CYCLES in RUN with exception 1. Without the macro: busy stays 1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types for the multiply/divide initiator: FSM states, operation select
// and the default datapath width.
package multdiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

endpackage

// File: rtl/multdiv_timeout.sv
// Watchdog for the RUN phase: counts RUN cycles and flags expiry on the
// LIMIT-th one. Only instantiated when MULTDIV_TIMEOUT_EN is defined.
module multdiv_timeout #(
    parameter int unsigned LIMIT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter reads LIMIT-1 during the LIMIT-th cycle spent in RUN.
    assign expired = count_en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Initiator side of the iterative multiply/divide unit interface.
// Define MULTDIV_TIMEOUT_EN to add a RUN-phase watchdog (multdiv_timeout).
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned UNIT_CYCLES    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] unit_operandA,
    output logic [WIDTH-1:0] unit_operandB,
    output logic             mult_clr,
    output logic             div_clr,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_exception,
    input  logic             mult_rdy,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_exception,
    input  logic             div_rdy,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // The watchdog is meaningless unless it outlasts a normal unit run.
    if (TIMEOUT_CYCLES <= UNIT_CYCLES) begin : g_bad_cfg
        $error("multdiv_ctrl: TIMEOUT_CYCLES must exceed UNIT_CYCLES");
    end

    state_e             state_q,  state_d;
    op_e                op_q,     op_d;
    logic [WIDTH-1:0]   opa_q,    opa_d;
    logic [WIDTH-1:0]   opb_q,    opb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q,    exc_d;
    logic               busy_q,   busy_d;
    logic               rdy_q,    rdy_d;

    logic               sel_rdy;
    logic [WIDTH-1:0]   sel_result;
    logic               sel_exc;
    logic               timeout_hit;

    assign sel_rdy    = (op_q == OP_DIV) ? div_rdy       : mult_rdy;
    assign sel_result = (op_q == OP_DIV) ? div_result    : mult_result;
    assign sel_exc    = (op_q == OP_DIV) ? div_exception : mult_exception;

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_timeout #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == START),
        .count_en (state_q == RUN),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            IDLE:  state_d = IDLE;
            START: state_d = RUN;   // rdy is stale here and deliberately ignored
            RUN: begin
                if (sel_rdy) begin
                    state_d  = DONE;
                    result_d = sel_result;
                    exc_d    = sel_exc;
                end else if (timeout_hit) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new request in any state wins over whatever is in flight.
        if (ctrl_MULT && ctrl_DIV) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
        end else if (ctrl_DIV && (data_operandB == '0)) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
        end else if (ctrl_MULT || ctrl_DIV) begin
            state_d  = START;
            op_d     = ctrl_DIV ? OP_DIV : OP_MULT;
            opa_d    = data_operandA;
            opb_d    = data_operandB;
            result_d = result_q;    // an aborted op must not disturb the held result
            exc_d    = exc_q;
        end

        busy_d = (state_d == START) || (state_d == RUN);
        rdy_d  = (state_d == DONE);
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    assign unit_operandA  = opa_q;
    assign unit_operandB  = opb_q;
    assign mult_clr       = (state_q == START) && (op_q == OP_MULT);
    assign div_clr        = (state_q == START) && (op_q == OP_DIV);
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and compares on every data_resultRDY pulse.
module tb_multdiv_ctrl;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ctrl_MULT = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] unit_operandA;
    logic [W-1:0] unit_operandB;
    logic         mult_clr;
    logic         div_clr;
    logic [W-1:0] mult_result = '0;
    logic         mult_exception = 1'b0;
    logic         mult_rdy = 1'b0;
    logic [W-1:0] div_result = '0;
    logic         div_exception = 1'b0;
    logic         div_rdy = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    multdiv_ctrl #(
        .WIDTH          (W),
        .UNIT_CYCLES    (32),
        .TIMEOUT_CYCLES (40)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .unit_operandA  (unit_operandA),
        .unit_operandB  (unit_operandB),
        .mult_clr       (mult_clr),
        .div_clr        (div_clr),
        .mult_result    (mult_result),
        .mult_exception (mult_exception),
        .mult_rdy       (mult_rdy),
        .div_result     (div_result),
        .div_exception  (div_exception),
        .div_rdy        (div_rdy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Unit models: after seeing clr, count down `delay` edges then raise rdy and
    // hold it. rdy from the previous op stays up through the START cycle.
    int           mult_delay = 32;
    logic [W-1:0] mult_res = '0;
    bit           mult_hang = 1'b0;
    int           mult_cnt = 0;
    int           div_delay = 32;
    logic [W-1:0] div_res = '0;
    int           div_cnt = 0;

    always @(posedge clock) begin
        #1;
        if (mult_clr) begin
            mult_cnt = mult_hang ? 0 : mult_delay;
            if (mult_hang) mult_rdy = 1'b0;
        end else if (mult_cnt > 0) begin
            mult_cnt--;
            mult_rdy = (mult_cnt == 0);
            if (mult_cnt == 0) mult_result = mult_res;
        end
        if (div_clr) begin
            div_cnt = div_delay;
        end else if (div_cnt > 0) begin
            div_cnt--;
            div_rdy = (div_cnt == 0);
            if (div_cnt == 0) div_result = div_res;
        end
    end

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (data_resultRDY) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rdy: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check("rdy_cycle", 64'(cyc), 64'(e.cyc));
                check("result", 64'(data_result), 64'(e.res));
                check("exception", 64'(data_exception), 64'(e.exc));
            end
        end
    end

    // Drive a one-cycle request; t is the request cycle. Returns in cycle t+1.
    task automatic issue(input logic m, input logic d, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit has_exp,
                         input logic [W-1:0] res, input logic exc, input int lat,
                         output int t);
        exp_t e;
        @(posedge clock);
        #1;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        t             = cyc;
        if (has_exp) begin
            e.res = res;
            e.exc = exc;
            e.cyc = t + lat;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int t;
        int t0;

        // Reset and idle state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdy", 64'(data_resultRDY), 64'd0);
        check("rst_result", 64'(data_result), 64'd0);
        check("rst_clr", 64'({mult_clr, div_clr}), 64'd0);
        check("rst_operands", 64'({unit_operandA, unit_operandB}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_exc", 64'(data_exception), 64'd0);

        // Multiply 7 * -3.
        mult_delay = 32;
        mult_res   = 32'hFFFF_FFEB;
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0, 34, t);
        @(negedge clock);
        check("mul_mult_clr", 64'(mult_clr), 64'd1);
        check("mul_div_clr", 64'(div_clr), 64'd0);
        check("mul_busy_start", 64'(busy), 64'd1);
        @(negedge clock);
        check("mul_clr_once", 64'(mult_clr), 64'd0);
        check("mul_opA", 64'(unit_operandA), 64'd7);
        check("mul_opB", 64'(unit_operandB), 64'hFFFF_FFFD);
        check("mul_busy_run", 64'(busy), 64'd1);
        wait_drain(60);
        repeat (2) @(negedge clock);
        check("mul_busy_after", 64'(busy), 64'd0);
        check("mul_hold", 64'(data_result), 64'hFFFF_FFEB);

        // Divide 100 / 7 with a stale high div_rdy during START.
        div_rdy    = 1'b1;
        div_result = 32'h0000_DEAD;
        div_delay  = 32;
        div_res    = 32'd14;
        issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 34, t);
        @(negedge clock);
        check("div_div_clr", 64'(div_clr), 64'd1);
        check("div_mult_clr", 64'(mult_clr), 64'd0);
        @(negedge clock);
        check("div_clr_once", 64'(div_clr), 64'd0);
        check("div_busy_run", 64'(busy), 64'd1);
        wait_drain(60);

        // Divide by zero short-circuits without starting the unit.
        issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1, 1, t);
        @(negedge clock);
        check("dz_clr", 64'({mult_clr, div_clr}), 64'd0);
        check("dz_busy", 64'(busy), 64'd0);
        wait_drain(10);

        // Both ctrls high is illegal.
        issue(1'b1, 1'b1, 32'd3, 32'd4, 1'b1, 32'd0, 1'b1, 1, t);
        @(negedge clock);
        check("both_clr", 64'({mult_clr, div_clr}), 64'd0);
        wait_drain(10);

        // Multiply aborted by a divide 10 cycles later; only the divide completes.
        mult_res  = 32'h0000_1234;
        div_res   = 32'd10;
        issue(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 0, t0);
        repeat (8) @(posedge clock);
        issue(1'b0, 1'b1, 32'd50, 32'd5, 1'b1, 32'd10, 1'b0, 34, t);
        check("abort_spacing", 64'(t - t0), 64'd10);
        @(negedge clock);
        check("abort_div_clr", 64'(div_clr), 64'd1);
        check("abort_opA", 64'(unit_operandA), 64'd50);
        wait_drain(60);
        repeat (3) @(negedge clock);
        check("abort_hold", 64'(data_result), 64'd10);

        // Reset in RUN: busy drops at once, no completion pulse afterwards.
        issue(1'b1, 1'b0, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0, 0, t);
        repeat (5) @(negedge clock);
        check("rrun_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rrun_busy_drop", 64'(busy), 64'd0);
        check("rrun_result_clr", 64'(data_result), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("rrun_idle", 64'(busy), 64'd0);

        // Unit never answers.
        mult_hang = 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
        issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd0, 1'b1, 42, t);
        wait_drain(60);
`else
        issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b0, 32'd0, 1'b0, 0, t);
        repeat (60) @(negedge clock);
        check("hang_busy", 64'(busy), 64'd1);
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
